// File: rtl/shift_register_seq.sv
// -----------------------------------------------------------------------------
// shift_register_seq
//
// Command sequencer for an N-bit shift_register datapath. A host hands over
// one command at a time on a valid/ready handshake; each command parallel-loads
// a word into the datapath and then shifts it left or right a number of cycles.
// Completion is flagged with a single-cycle done pulse.
//
// The FSM is Moore-style: every output is a register updated in the same
// always_ff as the state, so nothing on the input side reaches an output
// combinationally.
//
// Optional feature (macro SHIFT_REGISTER_SEQ_PAUSE_EN):
//   Adds a 'pause' input. While in SHIFT, pause=1 holds the datapath
//   (sr_ctrl=00) and freezes the remaining shift count. Without the macro
//   there is no pause port and SHIFT always runs to completion.
//
// Parameters:
//   N   datapath width in bits (>= 2)
//   CW  width of the shift-count field, $clog2(N+1) (derived)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   cmd_valid  command present
//   cmd_ready  sequencer can accept a command (high only in IDLE)
//   cmd_dir    0 = shift right, 1 = shift left
//   cmd_data   word to parallel-load
//   cmd_count  number of shift cycles after the load (values > N act as N)
//   pause      (optional) stall shifting while high
//   sr_ctrl    datapath control: 00 hold, 01 right, 10 left, 11 load
//   sr_data    datapath parallel-load data (last loaded word)
//   busy       command in progress (LOAD, SHIFT, DONE)
//   done       one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module shift_register_seq #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_dir,
  input  logic [N-1:0]  cmd_data,
  input  logic [CW-1:0] cmd_count,
`ifdef SHIFT_REGISTER_SEQ_PAUSE_EN
  input  logic          pause,
`endif
  output logic [1:0]    sr_ctrl,
  output logic [N-1:0]  sr_data,
  output logic          busy,
  output logic          done
);

  // Datapath control encodings.
  typedef enum logic [1:0] {
    CTRL_HOLD  = 2'b00,
    CTRL_RIGHT = 2'b01,
    CTRL_LEFT  = 2'b10,
    CTRL_LOAD  = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e        state;
  logic          dir;
  // Shifts still to be issued to the datapath. Because sr_ctrl is registered,
  // a shift is "issued" at the edge that loads the shift code into sr_ctrl,
  // so the counter is decremented at that same edge. When it reads zero in
  // SHIFT, the last shift cycle is currently on the outputs and the next edge
  // moves to DONE. This yields exactly min(cmd_count, N) shift cycles.
  logic [CW-1:0] count;

  logic [CW-1:0] count_clamped;
  ctrl_e         shift_code;
  logic          stall;

  // NOTE: every variable assigned in an always_comb gets an unconditional
  // value on every path; a missing branch would infer a latch.
  always_comb begin
    count_clamped = cmd_count;
    if (cmd_count > CW'(N)) begin
      count_clamped = CW'(N);
    end
  end

  assign shift_code = dir ? CTRL_LEFT : CTRL_RIGHT;

`ifdef SHIFT_REGISTER_SEQ_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  // NOTE: state and output registers use non-blocking assignments so every
  // register samples pre-edge values; blocking assignments here would create
  // order-dependent simulation and mismatch the synthesized flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      dir       <= 1'b0;
      count     <= '0;
      sr_ctrl   <= CTRL_HOLD;
      sr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      // done is a pulse: it is raised only on the edge entering DONE.
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state     <= S_LOAD;
            sr_data   <= cmd_data;
            dir       <= cmd_dir;
            count     <= count_clamped;
            sr_ctrl   <= CTRL_LOAD;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end
        end

        S_LOAD: begin
          if (count == '0) begin
            state   <= S_DONE;
            sr_ctrl <= CTRL_HOLD;
            done    <= 1'b1;
          end else begin
            state   <= S_SHIFT;
            sr_ctrl <= shift_code;
            count   <= count - 1'b1;
          end
        end

        S_SHIFT: begin
          if (count == '0) begin
            state   <= S_DONE;
            sr_ctrl <= CTRL_HOLD;
            done    <= 1'b1;
          end else if (stall) begin
            // Hold the datapath; remaining count is left untouched.
            sr_ctrl <= CTRL_HOLD;
          end else begin
            sr_ctrl <= shift_code;
            count   <= count - 1'b1;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          sr_ctrl   <= CTRL_HOLD;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          sr_ctrl   <= CTRL_HOLD;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Structural invariants of the registered outputs.
  a_ready_not_busy : assert property (@(posedge clk) disable iff (!reset)
    cmd_ready == !busy);
  a_done_holds : assert property (@(posedge clk) disable iff (!reset)
    done |-> (sr_ctrl == CTRL_HOLD) && busy);
  a_done_pulse : assert property (@(posedge clk) disable iff (!reset)
    done |=> !done);
`endif

endmodule

// File: tb/tb_shift_register_seq.sv
module tb_shift_register_seq;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);
  localparam int SW = N + 5;

  // One observation per cycle: {sr_ctrl, sr_data, busy, done, cmd_ready}
  typedef logic [SW-1:0] snap_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [N-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
  logic          pause;
  logic [1:0]    sr_ctrl;
  logic [N-1:0]  sr_data;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  snap_t obs_q[$];
  snap_t exp_q[$];

  shift_register_seq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
`ifdef SHIFT_REGISTER_SEQ_PAUSE_EN
    .pause     (pause),
`endif
    .sr_ctrl   (sr_ctrl),
    .sr_data   (sr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic snap_t pack(input logic [1:0] c, input logic [N-1:0] d,
                                 input logic b, input logic dn, input logic r);
    return {c, d, b, dn, r};
  endfunction

  function automatic snap_t snap();
    return {sr_ctrl, sr_data, busy, done, cmd_ready};
  endfunction

  function automatic snap_t rst_snap();
    return pack(2'b00, '0, 1'b0, 1'b0, 1'b1);
  endfunction

  // Reference model: a command produces a LOAD cycle, min(count,N) shift
  // cycles (with optional hold cycles after the first shift), a DONE cycle,
  // and then an IDLE cycle where the loaded word is still presented.
  task automatic model_cmd(input logic dir, input logic [N-1:0] data,
                           input int count, input int pauses);
    int n;
    n = (count > N) ? N : count;
    exp_q.push_back(pack(2'b11, data, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(pack(dir ? 2'b10 : 2'b01, data, 1'b1, 1'b0, 1'b0));
      if (k == 0) begin
        for (int p = 0; p < pauses; p++)
          exp_q.push_back(pack(2'b00, data, 1'b1, 1'b0, 1'b0));
      end
    end
    exp_q.push_back(pack(2'b00, data, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(pack(2'b00, data, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
  endtask

  // Presents a command and passes the accepting edge.
  task automatic issue(input logic dir, input logic [N-1:0] data,
                       input logic [CW-1:0] cnt, input bit keep);
    cmd_dir   = dir;
    cmd_data  = data;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    step();
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Records len cycles starting with the cycle right after the accept edge.
  // With noise set, junk commands are presented while the sequencer is busy.
  task automatic capture(input int len, input int drop_at, input bit noise);
    for (int i = 0; i < len; i++) begin
      if (i > 0) step();
      obs_q.push_back(snap());
      if (i == drop_at || i == len - 1) begin
        cmd_valid = 1'b0;
      end else if (noise) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_data  = N'($urandom);
        cmd_count = CW'($urandom_range(0, (1 << CW) - 1));
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: cmd_ready=%b expected 1 within 50 cycles", name, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_data  = 8'hFF;
    cmd_count = CW'(3);
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (snap() !== rst_snap()) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, snap(), rst_snap());
      end
    end
    cmd_valid = 1'b0;
    reset     = 1'b1;
    step();
    // Asynchronous assertion in the middle of a shift cycle.
    issue(1'b1, 8'h3C, CW'(5), 1'b0);
    step();
    step();
    checks++;
    if (snap() !== pack(2'b10, 8'h3C, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_async_pre: got %b expected %b", snap(),
               pack(2'b10, 8'h3C, 1'b1, 1'b0, 1'b0));
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (snap() !== rst_snap()) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", snap(), rst_snap());
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_left_shift();
    wait_ready("left");
    clear_q();
    model_cmd(1'b1, 8'h55, 3, 0);
    issue(1'b1, 8'h55, CW'(3), 1'b0);
    capture(exp_q.size(), -1, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL left_shift[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_clamp();
    logic [N-1:0] d;
    int cnts[3] = '{0, 12, (1 << CW) - 1};
    for (int t = 0; t < 3; t++) begin
      wait_ready("zero_clamp");
      clear_q();
      d = (t == 0) ? 8'hAA : N'($urandom);
      model_cmd(1'b0, d, cnts[t], 0);
      issue(1'b0, d, CW'(cnts[t]), 1'b0);
      capture(exp_q.size(), -1, 1'b0);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL zero_clamp_c%0d[%0d]: got %b expected %b",
                   cnts[t], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] da, db;
    da = N'($urandom);
    db = N'($urandom);
    wait_ready("b2b");
    clear_q();
    model_cmd(1'b0, da, 2, 0);
    exp_q.pop_back();  // IDLE cycle of A is where B is accepted
    exp_q.push_back(pack(2'b00, da, 1'b0, 1'b0, 1'b1));
    model_cmd(1'b1, db, 1, 0);
    issue(1'b0, da, CW'(2), 1'b1);
    cmd_dir   = 1'b1;
    cmd_data  = db;
    cmd_count = CW'(1);
    capture(exp_q.size(), 5, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic          d;
    logic [N-1:0]  w;
    logic [CW-1:0] c;
    int            bad;
    for (int t = 0; t < 25; t++) begin
      wait_ready("random");
      repeat ($urandom_range(0, 3)) step();
      clear_q();
      d = 1'($urandom_range(0, 1));
      w = N'($urandom);
      c = CW'($urandom_range(0, (1 << CW) - 1));
      model_cmd(d, w, int'(c), 0);
      issue(d, w, c, 1'b0);
      capture(exp_q.size(), -1, 1'b1);
      bad = 0;
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          bad++;
          if (bad <= 3)
            $display("FAIL random_t%0d[%0d] dir=%b cnt=%0d: got %b expected %b",
                     t, i, d, c, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] w;
    w = N'($urandom);
    wait_ready("reset_mid");
    clear_q();
    model_cmd(1'b0, w, 6, 0);
    issue(1'b0, w, CW'(6), 1'b0);
    capture(4, -1, 1'b0);  // LOAD plus three shift cycles
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_pre[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (snap() !== rst_snap()) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %b expected %b", i, snap(), rst_snap());
      end
      if (i < 3) step();
    end
    reset = 1'b1;
    step();
    clear_q();
    w = N'($urandom);
    model_cmd(1'b1, w, 2, 0);
    issue(1'b1, w, CW'(2), 1'b0);
    capture(exp_q.size(), -1, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_after[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef SHIFT_REGISTER_SEQ_PAUSE_EN
  task automatic test_pause();
    logic [N-1:0] w;
    w = N'($urandom);
    wait_ready("pause");
    clear_q();
    model_cmd(1'b1, w, 4, 2);
    issue(1'b1, w, CW'(4), 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      obs_q.push_back(snap());
      if (i == 1) pause = 1'b1;
      if (i == 3) pause = 1'b0;
    end
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL pause[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_data  = '0;
    cmd_count = '0;
    pause     = 1'b0;
    test_reset();
    test_left_shift();
    test_zero_clamp();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef SHIFT_REGISTER_SEQ_PAUSE_EN
    test_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
